// File: rtl/ssit_pkg.sv
// Shared store-set definitions: table geometry, SSID type and the PC index hash.
// The LFST and load/store queue reuse SSID_W and ssid_t from here.
package ssit_pkg;

    localparam int IDX_W   = 10;
    localparam int SSID_W  = 7;
    localparam int PC_W    = 64;
    localparam int N_SLOTS = 4;

    typedef logic [SSID_W-1:0] ssid_t;
    typedef logic [IDX_W-1:0]  idx_t;

    // Only PC bits [2*IDX_W+1:2] take part; [1:0] are always zero for 4-byte instructions.
    function automatic idx_t ssit_idx(input logic [2*IDX_W+1:2] pc_bits);
        return pc_bits[IDX_W+1:2] ^ pc_bits[2*IDX_W+1:IDX_W+2];
    endfunction

endpackage

// File: rtl/ssit_if.sv
// Decode-side lookup and violation-training bus of the store set ID table.
interface ssit_if;
    import ssit_pkg::*;

    // No back-pressure: every cycle is accepted. instN_vld_i qualifies instN_pc_i,
    // viol_vld_i qualifies both violation PCs, instN_ssid_vld_o qualifies instN_ssid_o.
    logic              inst0_vld_i, inst1_vld_i, inst2_vld_i, inst3_vld_i;
    logic [PC_W-1:0]   inst0_pc_i,  inst1_pc_i,  inst2_pc_i,  inst3_pc_i;
    logic              viol_vld_i;
    logic [PC_W-1:0]   viol_ld_pc_i;
    logic [PC_W-1:0]   viol_st_pc_i;
    ssid_t             inst0_ssid_o, inst1_ssid_o, inst2_ssid_o, inst3_ssid_o;
    logic              inst0_ssid_vld_o, inst1_ssid_vld_o, inst2_ssid_vld_o, inst3_ssid_vld_o;

    modport master (
        output inst0_vld_i, inst1_vld_i, inst2_vld_i, inst3_vld_i,
        output inst0_pc_i, inst1_pc_i, inst2_pc_i, inst3_pc_i,
        output viol_vld_i, viol_ld_pc_i, viol_st_pc_i,
        input  inst0_ssid_o, inst1_ssid_o, inst2_ssid_o, inst3_ssid_o,
        input  inst0_ssid_vld_o, inst1_ssid_vld_o, inst2_ssid_vld_o, inst3_ssid_vld_o
    );

    modport slave (
        input  inst0_vld_i, inst1_vld_i, inst2_vld_i, inst3_vld_i,
        input  inst0_pc_i, inst1_pc_i, inst2_pc_i, inst3_pc_i,
        input  viol_vld_i, viol_ld_pc_i, viol_st_pc_i,
        output inst0_ssid_o, inst1_ssid_o, inst2_ssid_o, inst3_ssid_o,
        output inst0_ssid_vld_o, inst1_ssid_vld_o, inst2_ssid_vld_o, inst3_ssid_vld_o
    );

endinterface

// File: rtl/ssit_viol_update.sv
// Store-set assignment/merge decision for one load/store violation pair (combinational).
module ssit_viol_update
    import ssit_pkg::*;
(
    input  logic  l_vld,
    input  logic  s_vld,
    input  ssid_t l_ssid,
    input  ssid_t s_ssid,
    input  ssid_t alloc_cnt,
    output logic  l_we,
    output logic  s_we,
    output ssid_t l_wdata,
    output ssid_t s_wdata,
    output logic  alloc_inc
);

    ssid_t min_ssid;

    assign min_ssid = (l_ssid < s_ssid) ? l_ssid : s_ssid;

    // When load and store alias to one entry, both write ports carry identical data.
    always_comb begin
        l_we      = 1'b0;
        s_we      = 1'b0;
        l_wdata   = l_ssid;
        s_wdata   = s_ssid;
        alloc_inc = 1'b0;
        case ({l_vld, s_vld})
            2'b00: begin
                l_we      = 1'b1;
                s_we      = 1'b1;
                l_wdata   = alloc_cnt;
                s_wdata   = alloc_cnt;
                alloc_inc = 1'b1;
            end
            2'b10: begin
                s_we    = 1'b1;
                s_wdata = l_ssid;
            end
            2'b01: begin
                l_we    = 1'b1;
                l_wdata = s_ssid;
            end
            default: begin
                if (l_ssid != s_ssid) begin
                    l_we    = 1'b1;
                    s_we    = 1'b1;
                    l_wdata = min_ssid;
                    s_wdata = min_ssid;
                end
            end
        endcase
    end

endmodule

// File: rtl/ssit.sv
// Store Set ID Table: 4-wide registered SSID lookup, trained by memory-order violations.
// Optional periodic decay of all valid bits under SSIT_PERIODIC_CLEAR_EN.
module ssit
    import ssit_pkg::*;
`ifdef SSIT_PERIODIC_CLEAR_EN
#(
    parameter int CLR_CNT_W      = 20,
    parameter int CLEAR_INTERVAL = 1000000
)
`endif
(
    input  logic    clock,
    input  logic    reset_n,
    input  logic    flush_i,
    input  logic    stall_i,
    ssit_if.slave   bus,
    output logic    ssit_clr_o
);

    localparam int ENTRIES = 2**IDX_W;

    ssid_t                ssid_mem [ENTRIES];
    logic [ENTRIES-1:0]   vld_mem;
    ssid_t                alloc_cnt;

    logic [N_SLOTS-1:0]   slot_vld;
    logic [PC_W-1:0]      slot_pc [N_SLOTS];
    idx_t                 rd_idx  [N_SLOTS];
    ssid_t                ssid_q  [N_SLOTS];
    logic [N_SLOTS-1:0]   vld_q;

    idx_t                 l_idx, s_idx;
    logic                 l_we, s_we, alloc_inc;
    ssid_t                l_wdata, s_wdata;
    logic                 clear_now;
    logic                 unused_pc_bits;

    assign slot_vld   = {bus.inst3_vld_i, bus.inst2_vld_i, bus.inst1_vld_i, bus.inst0_vld_i};
    assign slot_pc[0] = bus.inst0_pc_i;
    assign slot_pc[1] = bus.inst1_pc_i;
    assign slot_pc[2] = bus.inst2_pc_i;
    assign slot_pc[3] = bus.inst3_pc_i;

    assign l_idx = ssit_idx(bus.viol_ld_pc_i[2*IDX_W+1:2]);
    assign s_idx = ssit_idx(bus.viol_st_pc_i[2*IDX_W+1:2]);

    always_comb begin
        unused_pc_bits = ^{bus.viol_ld_pc_i[PC_W-1:2*IDX_W+2], bus.viol_ld_pc_i[1:0],
                           bus.viol_st_pc_i[PC_W-1:2*IDX_W+2], bus.viol_st_pc_i[1:0]};
        for (int n = 0; n < N_SLOTS; n++) begin
            rd_idx[n]      = ssit_idx(slot_pc[n][2*IDX_W+1:2]);
            unused_pc_bits = unused_pc_bits ^ (^{slot_pc[n][PC_W-1:2*IDX_W+2], slot_pc[n][1:0]});
        end
    end

    ssit_viol_update u_viol_update (
        .l_vld     (vld_mem[l_idx]),
        .s_vld     (vld_mem[s_idx]),
        .l_ssid    (ssid_mem[l_idx]),
        .s_ssid    (ssid_mem[s_idx]),
        .alloc_cnt (alloc_cnt),
        .l_we      (l_we),
        .s_we      (s_we),
        .l_wdata   (l_wdata),
        .s_wdata   (s_wdata),
        .alloc_inc (alloc_inc)
    );

`ifdef SSIT_PERIODIC_CLEAR_EN
    logic [CLR_CNT_W-1:0] clr_cnt;
    logic                 clr_q;

    assign clear_now  = (clr_cnt == CLR_CNT_W'(CLEAR_INTERVAL - 1));
    assign ssit_clr_o = clr_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clr_cnt <= '0;
            clr_q   <= 1'b0;
        end else begin
            clr_q   <= clear_now;
            clr_cnt <= clear_now ? '0 : clr_cnt + 1'b1;
        end
    end
`else
    assign clear_now  = 1'b0;
    assign ssit_clr_o = 1'b0;
`endif

    // A clear cycle drops any violation; SSIDs and alloc_cnt survive the clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_mem   <= '0;
            alloc_cnt <= '0;
            for (int i = 0; i < ENTRIES; i++) ssid_mem[i] <= '0;
        end else if (clear_now) begin
            vld_mem <= '0;
        end else if (bus.viol_vld_i) begin
            if (l_we) begin
                ssid_mem[l_idx] <= l_wdata;
                vld_mem[l_idx]  <= 1'b1;
            end
            if (s_we) begin
                ssid_mem[s_idx] <= s_wdata;
                vld_mem[s_idx]  <= 1'b1;
            end
            if (alloc_inc) alloc_cnt <= alloc_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int n = 0; n < N_SLOTS; n++) ssid_q[n] <= '0;
        end else if (flush_i) begin
            vld_q <= '0;
            for (int n = 0; n < N_SLOTS; n++) ssid_q[n] <= '0;
        end else if (!stall_i) begin
            for (int n = 0; n < N_SLOTS; n++) begin
                ssid_q[n] <= ssid_mem[rd_idx[n]];
                vld_q[n]  <= vld_mem[rd_idx[n]] & slot_vld[n];
            end
        end
    end

    assign bus.inst0_ssid_o     = ssid_q[0];
    assign bus.inst1_ssid_o     = ssid_q[1];
    assign bus.inst2_ssid_o     = ssid_q[2];
    assign bus.inst3_ssid_o     = ssid_q[3];
    assign bus.inst0_ssid_vld_o = vld_q[0];
    assign bus.inst1_ssid_vld_o = vld_q[1];
    assign bus.inst2_ssid_vld_o = vld_q[2];
    assign bus.inst3_ssid_vld_o = vld_q[3];

endmodule

// File: tb/tb_ssit.sv
// Directed bench for ssit: behavioural table model checked every cycle plus literal expectations.
// Build with SSIT_PERIODIC_CLEAR_EN defined to exercise the periodic clear (interval 16).
`timescale 1ns/1ps
module tb_ssit;
    import ssit_pkg::*;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic flush_i = 1'b0;
    logic stall_i = 1'b0;
    logic ssit_clr_o;

    logic [3:0]  t_vld = '0;
    logic [63:0] t_pc [4] = '{default: '0};
    logic        t_viol = 1'b0;
    logic [63:0] t_ld = '0;
    logic [63:0] t_st = '0;
    logic [6:0]  o_ssid [4];
    logic        o_vld  [4];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    ssit_if bus();

`ifdef SSIT_PERIODIC_CLEAR_EN
    localparam int CLR_INTERVAL = 16;
    ssit #(.CLR_CNT_W(20), .CLEAR_INTERVAL(CLR_INTERVAL)) dut (
        .clock(clock), .reset_n(reset_n), .flush_i(flush_i), .stall_i(stall_i),
        .bus(bus), .ssit_clr_o(ssit_clr_o));
`else
    localparam int CLR_INTERVAL = 0;
    ssit dut (
        .clock(clock), .reset_n(reset_n), .flush_i(flush_i), .stall_i(stall_i),
        .bus(bus), .ssit_clr_o(ssit_clr_o));
`endif

    always #5 clock = ~clock;

    assign bus.inst0_vld_i  = t_vld[0];
    assign bus.inst1_vld_i  = t_vld[1];
    assign bus.inst2_vld_i  = t_vld[2];
    assign bus.inst3_vld_i  = t_vld[3];
    assign bus.inst0_pc_i   = t_pc[0];
    assign bus.inst1_pc_i   = t_pc[1];
    assign bus.inst2_pc_i   = t_pc[2];
    assign bus.inst3_pc_i   = t_pc[3];
    assign bus.viol_vld_i   = t_viol;
    assign bus.viol_ld_pc_i = t_ld;
    assign bus.viol_st_pc_i = t_st;
    assign o_ssid[0] = bus.inst0_ssid_o;
    assign o_ssid[1] = bus.inst1_ssid_o;
    assign o_ssid[2] = bus.inst2_ssid_o;
    assign o_ssid[3] = bus.inst3_ssid_o;
    assign o_vld[0]  = bus.inst0_ssid_vld_o;
    assign o_vld[1]  = bus.inst1_ssid_vld_o;
    assign o_vld[2]  = bus.inst2_ssid_vld_o;
    assign o_vld[3]  = bus.inst3_ssid_vld_o;

    // ---------------- behavioural model ----------------
    bit         m_valid [1024];
    logic [6:0] m_ssid  [1024];
    int         m_alloc;
    int         m_clr;
    bit         clear_now;
    logic [6:0] exp_ssid [4];
    bit         exp_vld  [4];
    bit         exp_clr;

    function automatic int hidx(input logic [63:0] pc);
        return int'(pc[11:2]) ^ int'(pc[21:12]);
    endfunction

    task automatic apply_viol(input logic [63:0] ld, input logic [63:0] st);
        int l, s, m;
        bit vl, vs;
        l  = hidx(ld);
        s  = hidx(st);
        vl = m_valid[l];
        vs = m_valid[s];
        if (!vl && !vs) begin
            m_ssid[l] = 7'(m_alloc);
            m_ssid[s] = 7'(m_alloc);
            m_valid[l] = 1'b1;
            m_valid[s] = 1'b1;
            m_alloc = (m_alloc + 1) % 128;
        end else if (!vs) begin
            m_ssid[s]  = m_ssid[l];
            m_valid[s] = 1'b1;
        end else if (!vl) begin
            m_ssid[l]  = m_ssid[s];
            m_valid[l] = 1'b1;
        end else if (m_ssid[l] != m_ssid[s]) begin
            m = (m_ssid[l] < m_ssid[s]) ? int'(m_ssid[l]) : int'(m_ssid[s]);
            m_ssid[l] = 7'(m);
            m_ssid[s] = 7'(m);
        end
    endtask

    always @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < 1024; i++) begin
                m_valid[i] = 1'b0;
                m_ssid[i]  = '0;
            end
            m_alloc = 0;
            m_clr   = 0;
            exp_clr = 1'b0;
            for (int n = 0; n < 4; n++) begin
                exp_ssid[n] = '0;
                exp_vld[n]  = 1'b0;
            end
        end else begin
            if (flush_i) begin
                for (int n = 0; n < 4; n++) begin
                    exp_ssid[n] = '0;
                    exp_vld[n]  = 1'b0;
                end
            end else if (!stall_i) begin
                for (int n = 0; n < 4; n++) begin
                    exp_ssid[n] = m_ssid[hidx(t_pc[n])];
                    exp_vld[n]  = m_valid[hidx(t_pc[n])] && t_vld[n];
                end
            end
            clear_now = (CLR_INTERVAL > 0) && (m_clr == CLR_INTERVAL - 1);
            exp_clr   = clear_now;
            m_clr     = clear_now ? 0 : m_clr + 1;
            if (clear_now) begin
                for (int i = 0; i < 1024; i++) m_valid[i] = 1'b0;
            end else if (t_viol) begin
                apply_viol(t_ld, t_st);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        bit ok;
        ok = 1'b1;
        for (int n = 0; n < 4; n++) begin
            if (o_ssid[n] !== exp_ssid[n] || o_vld[n] !== exp_vld[n]) begin
                ok = 1'b0;
                $display("FAIL model_cmp t=%0t slot%0d got ssid=%0d vld=%b required ssid=%0d vld=%b",
                         $time, n, o_ssid[n], o_vld[n], exp_ssid[n], exp_vld[n]);
            end
        end
        if (ssit_clr_o !== exp_clr) begin
            ok = 1'b0;
            $display("FAIL model_cmp_clr t=%0t got %b required %b", $time, ssit_clr_o, exp_clr);
        end
        n_checks++;
        if (!ok) n_err++;
    end

    // ---------------- driver tasks ----------------
    task automatic check_lit(input string name, input int got, input int req);
        n_checks++;
        if (got != req) begin
            n_err++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        cyc++;
    endtask

    task automatic do_reset();
        #1;
        reset_n = 1'b0;
        t_vld = '0; t_viol = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        cyc = 0;
    endtask

    task automatic set_look(input int slot, input logic [63:0] pc);
        t_vld[slot] = 1'b1;
        t_pc[slot]  = pc;
    endtask

    task automatic viol(input logic [63:0] ld, input logic [63:0] st);
        t_viol = 1'b1; t_ld = ld; t_st = st;
        tick();
        t_viol = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check_lit("reset_vld0", int'(o_vld[0]), 0);
        check_lit("reset_clr", int'(ssit_clr_o), 0);
`ifndef SSIT_PERIODIC_CLEAR_EN
        set_look(0, 64'h1000);
        tick();
        check_lit("empty_ssid", int'(o_ssid[0]), 0);
        check_lit("empty_vld", int'(o_vld[0]), 0);
        t_vld = '0;

        viol(64'h1000, 64'h2004);
        set_look(0, 64'h1000); set_look(1, 64'h2004);
        tick();
        check_lit("first_ld_ssid", int'(o_ssid[0]), 0);
        check_lit("first_ld_vld", int'(o_vld[0]), 1);
        check_lit("first_st_vld", int'(o_vld[1]), 1);
        t_vld = '0;

        viol(64'h5000, 64'h6008);
        set_look(0, 64'h5000); set_look(1, 64'h6008);
        tick();
        check_lit("second_ld_ssid", int'(o_ssid[0]), 1);
        check_lit("second_st_ssid", int'(o_ssid[1]), 1);
        t_vld = '0;

        // 0x3000 hashes onto the 0x2004 entry, so 0x4008 joins set 0.
        viol(64'h3000, 64'h4008);
        viol(64'h9000, 64'h9000);
        viol(64'ha000, 64'hc004);
        set_look(0, 64'h4008); set_look(1, 64'h9000); set_look(2, 64'ha000); set_look(3, 64'hc004);
        tick();
        check_lit("join_ssid", int'(o_ssid[0]), 0);
        check_lit("self_alias_ssid", int'(o_ssid[1]), 2);
        check_lit("after_alias_ssid", int'(o_ssid[3]), 3);
        t_vld = '0;

        t_viol = 1'b1; t_ld = 64'h20000; t_st = 64'h21000;
        set_look(0, 64'h20000);
        tick();
        t_viol = 1'b0;
        check_lit("no_bypass_vld", int'(o_vld[0]), 0);
        tick();
        check_lit("post_write_ssid", int'(o_ssid[0]), 4);
        check_lit("post_write_vld", int'(o_vld[0]), 1);
        t_vld = '0;

        set_look(0, 64'h1000); set_look(1, 64'h5000);
        tick();
        stall_i = 1'b1;
        t_pc[0] = 64'h20000; t_pc[1] = 64'ha000; set_look(2, 64'h9000);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_lit("stall_ssid1", int'(o_ssid[1]), 1);
            check_lit("stall_vld2", int'(o_vld[2]), 0);
        end
        flush_i = 1'b1;
        tick();
        check_lit("flush_vld0", int'(o_vld[0]), 0);
        check_lit("flush_ssid1", int'(o_ssid[1]), 0);
        flush_i = 1'b0; stall_i = 1'b0;
        tick();
        check_lit("resume_ssid2", int'(o_ssid[2]), 2);
        check_lit("resume_ssid0", int'(o_ssid[0]), 4);
        t_vld = '0;

        do_reset();
        viol(64'd100 << 2, 64'd101 << 2);
        viol(64'd102 << 2, 64'd103 << 2);
        viol(64'd104 << 2, 64'd105 << 2);
        viol(64'h2004,     64'd106 << 2);
        viol(64'd107 << 2, 64'd108 << 2);
        viol(64'h1000,     64'd109 << 2);
        set_look(0, 64'h1000); set_look(1, 64'h2004);
        tick();
        check_lit("pre_merge_ld", int'(o_ssid[0]), 5);
        check_lit("pre_merge_st", int'(o_ssid[1]), 3);
        viol(64'h1000, 64'h2004);
        set_look(2, 64'd109 << 2);
        tick();
        check_lit("merge_ld", int'(o_ssid[0]), 3);
        check_lit("merge_st", int'(o_ssid[1]), 3);
        check_lit("merge_other_member", int'(o_ssid[2]), 5);
        t_vld = '0;
        viol(64'h1000, 64'h2004);
        viol(64'd110 << 2, 64'd111 << 2);
        set_look(0, 64'd110 << 2);
        tick();
        check_lit("equal_no_alloc", int'(o_ssid[0]), 6);
        t_vld = '0;

        do_reset();
        for (int k = 0; k < 128; k++) begin
            viol(64'(256 + 2*k) << 2, 64'(257 + 2*k) << 2);
        end
        viol(64'd600 << 2, 64'd601 << 2);
        set_look(0, 64'd510 << 2); set_look(1, 64'd600 << 2); set_look(2, 64'd601 << 2);
        tick();
        check_lit("alloc_last", int'(o_ssid[0]), 127);
        check_lit("alloc_wrap_ssid", int'(o_ssid[1]), 0);
        check_lit("alloc_wrap_vld", int'(o_vld[2]), 1);
        t_vld = '0;
        tick();
`else
        begin
            int pulse_cyc;
            int waited;
            viol(64'h1000, 64'h2004);
            repeat (14) tick();
            t_viol = 1'b1; t_ld = 64'h5000; t_st = 64'h6008;
            set_look(0, 64'h1000);
            tick();
            t_viol = 1'b0;
            pulse_cyc = cyc;
            check_lit("clr_pulse", int'(ssit_clr_o), 1);
            check_lit("clr_cycle_lookup_vld", int'(o_vld[0]), 1);
            check_lit("clr_cycle_lookup_ssid", int'(o_ssid[0]), 0);
            set_look(0, 64'h1000); set_look(1, 64'h5000);
            tick();
            check_lit("after_clr_vld0", int'(o_vld[0]), 0);
            check_lit("after_clr_vld1", int'(o_vld[1]), 0);
            check_lit("clr_one_cycle", int'(ssit_clr_o), 0);
            t_vld = '0;
            viol(64'h7000, 64'h800c);
            set_look(0, 64'h7000);
            tick();
            check_lit("dropped_viol_alloc", int'(o_ssid[0]), 1);
            check_lit("post_clr_train_vld", int'(o_vld[0]), 1);
            t_vld = '0;
            waited = 0;
            while (ssit_clr_o !== 1'b1 && waited < 40) begin
                tick();
                waited++;
            end
            check_lit("clr_period", cyc - pulse_cyc, 16);
            tick();
        end
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
